// File: rtl/result_accumulator.sv
// Clocked consumer of the add/select datapath: sums a burst of COUNT {carry, result}
// samples into a wide accumulator. Define ACC_SATURATE_EN to clamp instead of wrap.
module result_accumulator #(
    parameter  int N_BITS   = 1,
    parameter  int ACC_BITS = 8,
    parameter  int COUNT    = 4,
    localparam int CNT_W    = $clog2(COUNT + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_BITS-1:0]   result,
    input  logic                carry_in,
    output logic [ACC_BITS-1:0] acc_out,
    output logic                acc_valid,
    output logic                overflow,
    output logic                busy,
    output logic [CNT_W-1:0]    sample_cnt
);

    localparam int SUM_W = ACC_BITS + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               xfer;
    logic               last_sample;
    logic [SUM_W-1:0]   sum_p0;

    // Bit ACC_BITS of the widened sum is the overflow indicator for this add.
    function automatic logic [ACC_BITS-1:0] fold_sum(input logic [SUM_W-1:0] s);
`ifdef ACC_SATURATE_EN
        fold_sum = s[ACC_BITS] ? {ACC_BITS{1'b1}} : s[ACC_BITS-1:0];
`else
        fold_sum = s[ACC_BITS-1:0];
`endif
    endfunction

    assign xfer        = in_valid && in_ready;
    assign last_sample = (sample_cnt == CNT_W'(COUNT - 1));
    assign sum_p0      = {1'b0, acc_out} + SUM_W'({carry_in, result});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (xfer && last_sample) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake/status flags are decoded from the next state so they are registered
    // yet line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            acc_valid  <= 1'b0;
            acc_out    <= '0;
            overflow   <= 1'b0;
            sample_cnt <= '0;
        end else begin
            in_ready  <= (state_next == ACCUM);
            busy      <= (state_next != IDLE);
            acc_valid <= (state_next == DONE);
            if (state == IDLE && start) begin
                acc_out    <= '0;
                overflow   <= 1'b0;
                sample_cnt <= '0;
            end else if (xfer) begin
                acc_out    <= fold_sum(sum_p0);
                sample_cnt <= sample_cnt + CNT_W'(1);
                if (sum_p0[ACC_BITS]) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_result_accumulator.sv
// Directed bench for result_accumulator: three instances (4-bit/COUNT=4, 3-bit/COUNT=4,
// 4-bit/COUNT=1) with queue-based expected totals.
module tb_result_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [0:0] result = '0;
    logic       carry_in = 1'b0;

    logic       start_c = 1'b0;
    logic       valid_c = 1'b0;
    logic [0:0] result_c = '0;
    logic       carry_c = 1'b0;

    logic       in_ready_a, acc_valid_a, overflow_a, busy_a;
    logic [3:0] acc_out_a;
    logic [2:0] sample_cnt_a;
    logic       in_ready_b, acc_valid_b, overflow_b, busy_b;
    logic [2:0] acc_out_b;
    logic [2:0] sample_cnt_b;
    logic       in_ready_c, acc_valid_c, overflow_c, busy_c;
    logic [3:0] acc_out_c;
    logic [0:0] sample_cnt_c;

    int n_checks = 0;
    int n_fail   = 0;
    int q_a[$];
    int q_b[$];
    int q_c[$];
    int exp_v;

    always #5 clk = ~clk;

    result_accumulator #(.N_BITS(1), .ACC_BITS(4), .COUNT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
        .result(result), .carry_in(carry_in), .acc_out(acc_out_a), .acc_valid(acc_valid_a),
        .overflow(overflow_a), .busy(busy_a), .sample_cnt(sample_cnt_a)
    );

    result_accumulator #(.N_BITS(1), .ACC_BITS(3), .COUNT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
        .result(result), .carry_in(carry_in), .acc_out(acc_out_b), .acc_valid(acc_valid_b),
        .overflow(overflow_b), .busy(busy_b), .sample_cnt(sample_cnt_b)
    );

    result_accumulator #(.N_BITS(1), .ACC_BITS(4), .COUNT(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .in_valid(valid_c), .in_ready(in_ready_c),
        .result(result_c), .carry_in(carry_c), .acc_out(acc_out_c), .acc_valid(acc_valid_c),
        .overflow(overflow_c), .busy(busy_c), .sample_cnt(sample_cnt_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic c, input logic r);
        in_valid = 1'b1;
        carry_in = c;
        result   = r;
        step();
        in_valid = 1'b0;
    endtask

    // Bounded wait for the done strobe, then pop the scoreboard and compare the total.
    task automatic finish_burst(input string tag);
        for (int k = 0; k < 20 && acc_valid_a !== 1'b1; k++) step();
        check({tag, "_valid"}, 32'(acc_valid_a), 32'd1);
        exp_v = (q_a.size() > 0) ? q_a.pop_front() : -1;
        check({tag, "_total"}, 32'(acc_out_a), 32'(exp_v));
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_acc", 32'(acc_out_a), 32'd0);
        check("rst_cnt", 32'(sample_cnt_a), 32'd0);
        check("rst_flags", 32'({in_ready_a, busy_a, acc_valid_a, overflow_a}), 32'd0);
        #20 rst_n = 1'b1;
        step();

        // Test 1: four back-to-back samples of 3
        q_a.push_back(12);
`ifdef ACC_SATURATE_EN
        q_b.push_back(7);
`else
        q_b.push_back(4);
`endif
        pulse_start();
        check("t1_ready", 32'(in_ready_a), 32'd1);
        check("t1_busy", 32'(busy_a), 32'd1);
        check("t1_clear", 32'(acc_out_a), 32'd0);
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 1'b1);
            check("t1_cnt", 32'(sample_cnt_a), 32'(i + 1));
            if (i < 3) check("t1_no_valid", 32'(acc_valid_a), 32'd0);
        end
        check("t1_ovf", 32'(overflow_a), 32'd0);
        check("t1_done_ready", 32'(in_ready_a), 32'd0);
        check("t1_done_busy", 32'(busy_a), 32'd1);
        finish_burst("t1");
        exp_v = (q_b.size() > 0) ? q_b.pop_front() : -1;
        check("t2_total", 32'(acc_out_b), 32'(exp_v));
        check("t2_ovf", 32'(overflow_b), 32'd1);
        check("t2_flags", 32'({acc_valid_b, busy_b, in_ready_b}), 32'b110);
        check("t2_cnt", 32'(sample_cnt_b), 32'd4);
        step();
        check("t1_strobe_end", 32'(acc_valid_a), 32'd0);
        check("t1_idle_busy", 32'(busy_a), 32'd0);
        step();
        check("t1_hold", 32'(acc_out_a), 32'd12);

        // Test 3: stall of three cycles between samples 2 and 3
        q_a.push_back(12);
        pulse_start();
        send(1'b1, 1'b1);
        send(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_stall_cnt", 32'(sample_cnt_a), 32'd2);
            check("t3_stall_ready", 32'(in_ready_a), 32'd1);
        end
        send(1'b1, 1'b1);
        send(1'b1, 1'b1);
        finish_burst("t3");
        step();

        // Test 4: asynchronous reset mid-burst, then a fresh burst of 1+2+3+0
        pulse_start();
        send(1'b1, 1'b1);
        send(1'b1, 1'b1);
        check("t4_pre_cnt", 32'(sample_cnt_a), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_acc", 32'(acc_out_a), 32'd0);
        check("t4_rst_cnt", 32'(sample_cnt_a), 32'd0);
        check("t4_rst_flags", 32'({in_ready_a, busy_a, acc_valid_a, overflow_a}), 32'd0);
        check("t4_rst_b", 32'({acc_out_b, overflow_b}), 32'd0);
        #2 rst_n = 1'b1;
        step();
        check("t4_idle", 32'(busy_a), 32'd0);
        q_a.push_back(6);
        pulse_start();
        send(1'b0, 1'b1);
        send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        finish_burst("t4");
        step();

        // Test 5: start during ACCUM and during DONE is ignored
        q_a.push_back(12);
        pulse_start();
        send(1'b1, 1'b1);
        pulse_start();
        check("t5_accum_cnt", 32'(sample_cnt_a), 32'd1);
        check("t5_accum_acc", 32'(acc_out_a), 32'd3);
        send(1'b1, 1'b1);
        send(1'b1, 1'b1);
        send(1'b1, 1'b1);
        finish_burst("t5");
        pulse_start();
        check("t5_done_idle", 32'({busy_a, in_ready_a}), 32'd0);
        check("t5_done_acc", 32'(acc_out_a), 32'd12);
        step();
        check("t5_still_idle", 32'(busy_a), 32'd0);

        // Test 6: COUNT=1 instance, single sample {0,1}
        q_c.push_back(1);
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        check("t6_ready", 32'(in_ready_c), 32'd1);
        valid_c  = 1'b1;
        carry_c  = 1'b0;
        result_c = 1'b1;
        step();
        valid_c = 1'b0;
        check("t6_valid", 32'(acc_valid_c), 32'd1);
        check("t6_cnt", 32'(sample_cnt_c), 32'd1);
        exp_v = (q_c.size() > 0) ? q_c.pop_front() : -1;
        check("t6_total", 32'(acc_out_c), 32'(exp_v));
        step();
        check("t6_strobe_end", 32'({acc_valid_c, busy_c, in_ready_c, overflow_c}), 32'd0);
        step();
        check("t6_hold", 32'(acc_out_c), 32'd1);

        check("sb_empty", 32'(q_a.size() + q_b.size() + q_c.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
